// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared types for the down-counting timer family.
//   timer_state_t : IDLE / RUN / DONE control states
//   timer_mode_t  : ONE_SHOT / PERIODIC reload behaviour at terminal count
// No ports; imported by the interface, the top and the optional prescaler.
// -----------------------------------------------------------------------------
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_t;

  typedef enum logic {
    ONE_SHOT = 1'b0,
    PERIODIC = 1'b1
  } timer_mode_t;

endpackage : timer_pkg

// File: rtl/down_timer_n_bit_if.sv
// -----------------------------------------------------------------------------
// down_timer_n_bit_if
// Control/status bundle of the down timer.
//   master modport (driver side) : load, load_data, start, stop, en, periodic
//                                  [prescale when TIMER_PRESCALER_EN is defined]
//                                  observes count, tc, busy, done
//   slave modport (timer side)   : the mirror image
// Parameters: n (count/reload width); PRESCALE_W exists only when
// TIMER_PRESCALER_EN is defined, together with the prescale signal.
// -----------------------------------------------------------------------------
interface down_timer_n_bit_if #(
  parameter int n = 4
`ifdef TIMER_PRESCALER_EN
  , parameter int PRESCALE_W = 8
`endif
);

  logic         load;
  logic [n-1:0] load_data;
  logic         start;
  logic         stop;
  logic         en;
  logic         periodic;
`ifdef TIMER_PRESCALER_EN
  logic [PRESCALE_W-1:0] prescale;
`endif
  logic [n-1:0] count;
  logic         tc;
  logic         busy;
  logic         done;

  modport master (
    output load, load_data, start, stop, en, periodic,
`ifdef TIMER_PRESCALER_EN
    output prescale,
`endif
    input  count, tc, busy, done
  );

  modport slave (
    input  load, load_data, start, stop, en, periodic,
`ifdef TIMER_PRESCALER_EN
    input  prescale,
`endif
    output count, tc, busy, done
  );

endinterface : down_timer_n_bit_if

// File: rtl/timer_prescaler.sv
// -----------------------------------------------------------------------------
// timer_prescaler
// Optional clock-enable divider for the down timer; the module exists only
// when TIMER_PRESCALER_EN is defined.
//   clk      : clock
//   reset    : synchronous active-high reset
//   clr      : synchronous restart of the divider (start/load/stop)
//   en       : advance enable; the divider only counts enabled cycles
//   prescale : divide ratio minus one
//   tick     : high on the enabled cycle that completes a prescale+1 group
// -----------------------------------------------------------------------------
`ifdef TIMER_PRESCALER_EN
module timer_prescaler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] prescale,
  output logic         tick
);

  logic [W-1:0] cnt_q;

  // ">=" rather than "==" so that lowering prescale below the current
  // count mid-run ends the group immediately instead of wrapping around.
  assign tick = (cnt_q >= prescale);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + W'(1);
    end
  end

endmodule : timer_prescaler
`endif

// File: rtl/down_timer_n_bit.sv
// -----------------------------------------------------------------------------
// down_timer_n_bit
// Programmable n-bit down-counting timer with one-shot / periodic modes.
// A reload value is written with load; start begins a countdown from it and
// every enabled cycle decrements the count. The edge that takes the count
// from 1 to 0 (or back to the reload value in periodic mode) raises tc for
// exactly one cycle.
//
// Ports:
//   clk   : clock, all state changes on its rising edge
//   reset : synchronous active-high reset
//   bus   : down_timer_n_bit_if.slave
//             in : load, load_data, start, stop, en, periodic [, prescale]
//             out: count, tc (registered pulse), busy (RUN), done (DONE)
//
// Build option: TIMER_PRESCALER_EN adds the PRESCALE_W parameter, the
// prescale input and a timer_prescaler instance; decrement then also
// requires its tick. Without it every enabled cycle is a tick.
//
// Event priority: reset > load > stop > start > decrement.
// load in the same cycle as start wins outright: the start is dropped and
// the state follows the load rules (RUN stays RUN, IDLE/DONE go to IDLE).
// -----------------------------------------------------------------------------
module down_timer_n_bit
  import timer_pkg::*;
#(
  parameter int n = 4
`ifdef TIMER_PRESCALER_EN
  , parameter int PRESCALE_W = 8
`endif
) (
  input logic              clk,
  input logic              reset,
  down_timer_n_bit_if.slave bus
);

  timer_state_t state_q;
  timer_state_t state_d;
  logic [n-1:0] count_q;
  logic [n-1:0] reload_q;
  logic         tc_q;

  timer_mode_t  mode;
  logic         tick;
  logic         start_ok;
  logic         dec_ok;
  logic         at_one;

  // Mode is sampled every cycle, so a run can be switched between one-shot
  // and periodic while it is counting.
  assign mode = bus.periodic ? PERIODIC : ONE_SHOT;

`ifdef TIMER_PRESCALER_EN
  timer_prescaler #(
    .W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .clr      (bus.start | bus.load | bus.stop),
    .en       (bus.en),
    .prescale (bus.prescale),
    .tick     (tick)
  );
`else
  assign tick = 1'b1;
`endif

  // A start is honoured only outside RUN, with a non-zero reload value and
  // no competing load/stop in the same cycle.
  assign start_ok = (state_q != RUN) && bus.start && !bus.stop && !bus.load &&
                    (reload_q != '0);

  // A decrement needs an enabled tick in RUN with nothing of higher
  // priority pending. A count already at zero (reached by loading 0 while
  // running) simply holds: no wrap-around, no tc.
  assign dec_ok = (state_q == RUN) && bus.en && tick && !bus.stop &&
                  !bus.load && (count_q != '0);

  assign at_one = (count_q == n'(1));

  // ---------------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) state_d = RUN;
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (dec_ok && at_one && (mode == ONE_SHOT)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.load) begin
          state_d = IDLE;
        end else if (start_ok) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: outputs (pure decodes of the registered state)
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.busy = (state_q == RUN);
    bus.done = (state_q == DONE);
  end

  // ---------------------------------------------------------------------------
  // Countdown datapath: count, reload value and the tc pulse register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      // dec_ok already excludes load and stop, so a competing load or stop
      // on the 1 -> 0 edge swallows the pulse.
      tc_q <= dec_ok && at_one;

      if (bus.load) begin
        count_q  <= bus.load_data;
        reload_q <= bus.load_data;
      end else if (start_ok) begin
        count_q <= reload_q;
      end else if (dec_ok) begin
        if (at_one) begin
          count_q <= (mode == PERIODIC) ? reload_q : '0;
        end else begin
          count_q <= count_q - n'(1);
        end
      end
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;

endmodule : down_timer_n_bit
